shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 164 ++++++++++++++++
 tb/tb_shift_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// Multi-cycle barrel shifter: one log2 stage per clock (SLL/SRL/SRA/ROL), with a
// sticky lost-bit flag, ready/valid handshakes and a synchronous abort.
module shift_unit #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         data,
    input  logic [$clog2(N)-1:0] shamt,
    input  logic [1:0]           mode,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         result,
    output logic                 lost
);

    localparam int SW = $clog2(N);
    localparam int KW = $clog2(SW);
    localparam logic [N-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [N-1:0]    work_q, work_d;
    logic [SW-1:0]   shamt_q, shamt_d;
    mode_e           mode_q, mode_d;
    logic            sign_q, sign_d;
    logic            lost_q, lost_d;

    logic [SW-1:0]   amt;
    logic [N-1:0]    mask_hi;
    logic [N-1:0]    mask_lo;
    logic [2*N-1:0]  rol_dbl;
    logic [N-1:0]    stage_res;
    logic            stage_lost;

    // Datapath for the current stage: shift by 2^k and collect the bits that fall off.
    always_comb begin
        amt        = SW'(1) << k_q;
        mask_hi    = ~(ONES >> amt);
        mask_lo    = ~(ONES << amt);
        rol_dbl    = {work_q, work_q} << amt;
        stage_res  = work_q;
        stage_lost = 1'b0;
        unique case (mode_q)
            MODE_SLL: begin
                stage_res  = work_q << amt;
                stage_lost = |(work_q & mask_hi);
            end
            MODE_SRL: begin
                stage_res  = work_q >> amt;
                stage_lost = |(work_q & mask_lo);
            end
            MODE_SRA: begin
                stage_res  = (work_q >> amt) | (sign_q ? mask_hi : '0);
                stage_lost = |(work_q & mask_lo);
            end
            MODE_ROL: begin
                stage_res  = rol_dbl[2*N-1:N];
                stage_lost = 1'b0;
            end
            default: begin
                stage_res  = work_q;
                stage_lost = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        lost_d  = lost_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = data;
                    shamt_d = shamt;
                    mode_d  = mode_e'(mode);
                    sign_d  = data[N-1];
                    lost_d  = 1'b0;
                    k_d     = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    work_d  = '0;
                    lost_d  = 1'b0;
                    k_d     = '0;
                    state_d = IDLE;
                end else begin
                    if (shamt_q[k_q]) begin
                        work_d = stage_res;
                        lost_d = lost_q | stage_lost;
                    end
                    if (k_q == KW'(SW - 1)) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            DONE: begin
                // Abort wins over the consumer taking the result.
                if (abort) begin
                    work_d  = '0;
                    lost_d  = 1'b0;
                    k_d     = '0;
                    state_d = IDLE;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            work_q  <= '0;
            shamt_q <= '0;
            mode_q  <= MODE_SLL;
            sign_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            lost_q  <= lost_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = work_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (N = 32): hand-computed vectors, handshake timing,
// backpressure, abort and asynchronous reset.
module tb_shift_unit;

    localparam int N  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  data;
    logic [SW-1:0] shamt;
    logic [1:0]    mode;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  result;
    logic          lost;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    always #5 clk = ~clk;

    shift_unit #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .shamt     (shamt),
        .mode      (mode),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .lost      (lost)
    );

    task automatic checkOutput(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
            $error("[TB] %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge where DONE is expected.
    task automatic applyStimulus(input string tag, input logic [N-1:0] d, input logic [SW-1:0] s,
                                 input logic [1:0] m, input logic with_abort);
        data     = d;
        shamt    = s;
        mode     = m;
        in_valid = 1'b1;
        abort    = with_abort;
        checkFlag({tag, " in_ready idle"}, in_ready, 1'b1);
        @(negedge clk);
        abort = 1'b0;
        data  = ~d;
        shamt = ~s;
        mode  = ~m;
        checkFlag({tag, " in_ready busy"}, in_ready, 1'b0);
        repeat (4) @(negedge clk);
        checkFlag({tag, " out_valid early"}, out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        checkFlag({tag, " out_valid latency"}, out_valid, 1'b1);
    endtask

    task automatic runOp(input string tag, input logic [N-1:0] d, input logic [SW-1:0] s,
                         input logic [1:0] m, input logic with_abort,
                         input logic [N-1:0] exp_res, input logic exp_lost);
        applyStimulus(tag, d, s, m, with_abort);
        checkOutput({tag, " result"}, result, exp_res);
        checkFlag({tag, " lost"}, lost, exp_lost);
        @(negedge clk);
        checkFlag({tag, " back to idle"}, in_ready, 1'b1);
        checkFlag({tag, " out_valid dropped"}, out_valid, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        data      = '0;
        shamt     = '0;
        mode      = SLL;
        #3;
        checkFlag("reset in_ready", in_ready, 1'b1);
        checkFlag("reset out_valid", out_valid, 1'b0);
        checkOutput("reset result", result, 32'h0);
        checkFlag("reset lost", lost, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        runOp("sll 1<<2",          32'h0000_0001, 5'd2,  SLL, 1'b0, 32'h0000_0004, 1'b0);
        runOp("sll lost",          32'hC000_0001, 5'd2,  SLL, 1'b0, 32'h0000_0004, 1'b1);
        runOp("srl 31",            32'h8000_0000, 5'd31, SRL, 1'b0, 32'h0000_0001, 1'b0);
        runOp("sra 31",            32'h8000_0000, 5'd31, SRA, 1'b0, 32'hFFFF_FFFF, 1'b0);
        runOp("rol 4",             32'h8000_0001, 5'd4,  ROL, 1'b0, 32'h0000_0018, 1'b0);
        runOp("shamt 0",           32'hDEAD_BEEF, 5'd0,  SRA, 1'b0, 32'hDEAD_BEEF, 1'b0);
        runOp("srl lost",          32'h0000_000F, 5'd4,  SRL, 1'b0, 32'h0000_0000, 1'b1);
        runOp("sra neg lost",      32'h8000_000F, 5'd4,  SRA, 1'b0, 32'hF800_0000, 1'b1);
        runOp("rol wrap",          32'hF000_000F, 5'd4,  ROL, 1'b0, 32'h0000_00FF, 1'b0);
        runOp("sll 31",            32'h0000_0003, 5'd31, SLL, 1'b0, 32'h8000_0000, 1'b1);
        runOp("abort+valid idle",  32'h0000_000F, 5'd4,  SRL, 1'b1, 32'h0000_0000, 1'b1);

        // Backpressure: result held while in_valid pulses are ignored.
        out_ready = 1'b0;
        applyStimulus("bp", 32'hC000_0001, 5'd2, SLL, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            data     = 32'hFFFF_FFFF;
            shamt    = 5'd0;
            @(negedge clk);
            checkFlag("bp out_valid held", out_valid, 1'b1);
            checkFlag("bp in_ready low", in_ready, 1'b0);
            checkOutput("bp result held", result, 32'h0000_0004);
            checkFlag("bp lost held", lost, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkFlag("bp release idle", in_ready, 1'b1);
        checkFlag("bp release out_valid", out_valid, 1'b0);
        @(negedge clk);
        checkFlag("bp nothing queued", in_ready, 1'b1);

        // Abort on the edge that would execute stage 2.
        data     = 32'h0000_0001;
        shamt    = 5'd7;
        mode     = SLL;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkFlag("abort out_valid s1", out_valid, 1'b0);
        @(negedge clk);
        checkOutput("abort pre result", result, 32'h0000_0008);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkFlag("abort in_ready", in_ready, 1'b1);
        checkFlag("abort out_valid", out_valid, 1'b0);
        checkOutput("abort result", result, 32'h0);
        checkFlag("abort lost", lost, 1'b0);
        runOp("post abort", 32'h8000_0001, 5'd4, ROL, 1'b0, 32'h0000_0018, 1'b0);

        // Abort in DONE beats out_ready and clears the result.
        applyStimulus("done abort", 32'hC000_0001, 5'd2, SLL, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkFlag("done abort out_valid", out_valid, 1'b0);
        checkFlag("done abort in_ready", in_ready, 1'b1);
        checkOutput("done abort result", result, 32'h0);
        checkFlag("done abort lost", lost, 1'b0);

        // Asynchronous reset in the middle of SHIFT.
        data     = 32'hC000_0001;
        shamt    = 5'd2;
        mode     = SLL;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid shift result", result, 32'h0000_0004);
        #2 rst_n = 1'b0;
        #1;
        checkFlag("async rst out_valid", out_valid, 1'b0);
        checkFlag("async rst in_ready", in_ready, 1'b1);
        checkOutput("async rst result", result, 32'h0);
        checkFlag("async rst lost", lost, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("post reset", 32'h0000_0001, 5'd0, SLL, 1'b0, 32'h0000_0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
